// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, FSM state
// type, data-word width and the low-address alignment helper.
package lsu_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_R = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        LD,
        MERGE,
        WR,
        DONE
    } lsu_state_e;

    // Clear the low address bits that a half/word access cannot use.
    function automatic logic [1:0] align_lane(input logic [1:0] size,
                                              input logic [1:0] offset);
        logic [1:0] lane;
        case (size)
            SIZE_H:  lane = {offset[1], 1'b0};
            SIZE_W:  lane = 2'b00;
            default: lane = offset;
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane handling for the load/store unit: extracts and extends the addressed
// byte/half of a RAM word for loads, and splices store data into a RAM word
// for partial stores. Purely combinational. Little-endian lanes.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        lane,
    input  logic              is_unsigned,
    input  logic [WORD_W-1:0] rdata,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] merge_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane out of the read word and extend it.
    always_comb begin
        case (lane)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SIZE_B:  load_data = is_unsigned ? {24'h0, byte_sel}
                                             : {{24{byte_sel[7]}}, byte_sel};
            SIZE_H:  load_data = is_unsigned ? {16'h0, half_sel}
                                             : {{16{half_sel[15]}}, half_sel};
            default: load_data = rdata;
        endcase
    end

    // Replace only the addressed lane(s); every other byte keeps its RAM value.
    always_comb begin
        merge_data = rdata;
        case (size)
            SIZE_B:  merge_data[{lane, 3'b000} +: 8]        = wdata[7:0];
            SIZE_H:  merge_data[{lane[1], 4'b0000} +: 16]   = wdata[15:0];
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between a core request port and a single-port synchronous
// 32-bit RAM. Loads and partial stores read the word first; partial stores
// merge and write it back; word stores write directly. All outputs are
// registered. Build option LSU_MISALIGN_TRAP_EN: misaligned half/word
// accesses are rejected with resp_err instead of being force-aligned.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [WORD_W-1:0]     req_wdata,
    output logic                  resp_valid,
    output logic [WORD_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [WORD_W-1:0]     ram_data,
    output logic                  ram_we,
    input  logic [WORD_W-1:0]     ram_q
);

    lsu_state_e            state, state_next;
    logic [1:0]            size_q, size_next;
    logic [1:0]            lane_q, lane_next;
    logic                  uns_q, uns_next;
    logic                  we_q, we_next;
    logic [ADDR_WIDTH-1:0] ram_addr_next;
    logic [WORD_W-1:0]     ram_data_next;
    logic [WORD_W-1:0]     rdata_next;
    logic                  err_next;
    logic                  misalign;
    logic [WORD_W-1:0]     load_data;
    logic [WORD_W-1:0]     merge_data;
    logic                  unused_addr_bits;

    // Address bits above the RAM depth wrap and are intentionally ignored.
    assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = (req_size == SIZE_H && req_addr[0]) ||
                      (req_size == SIZE_W && req_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // ram_data holds the store data until MERGE overwrites it with the merged word.
    lsu_align u_align (
        .size        (size_q),
        .lane        (lane_q),
        .is_unsigned (uns_q),
        .rdata       (ram_q),
        .wdata       (ram_data),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    // Next-state logic and next values of the registered outputs/latched request.
    always_comb begin
        state_next    = state;
        size_next     = size_q;
        lane_next     = lane_q;
        uns_next      = uns_q;
        we_next       = we_q;
        ram_addr_next = ram_addr;
        ram_data_next = ram_data;
        rdata_next    = resp_rdata;
        err_next      = resp_err;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    size_next     = req_size;
                    lane_next     = align_lane(req_size, req_addr[1:0]);
                    uns_next      = req_unsigned;
                    we_next       = req_we;
                    ram_addr_next = req_addr[ADDR_WIDTH+1:2];
                    ram_data_next = req_wdata;
                    rdata_next    = '0;
                    err_next      = 1'b0;
                    if (req_size == SIZE_R || misalign) begin
                        err_next   = 1'b1;
                        state_next = DONE;
                    end else if (req_we && req_size == SIZE_W) begin
                        state_next = WR;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD:      state_next = we_q ? MERGE : LD;
            LD: begin
                rdata_next = load_data;
                state_next = DONE;
            end
            MERGE: begin
                ram_data_next = merge_data;
                state_next    = WR;
            end
            WR:      state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, latched request and registered outputs; synchronous reset aborts any access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            size_q     <= SIZE_B;
            lane_q     <= 2'b00;
            uns_q      <= 1'b0;
            we_q       <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_data   <= '0;
        end else begin
            state      <= state_next;
            size_q     <= size_next;
            lane_q     <= lane_next;
            uns_q      <= uns_next;
            we_q       <= we_next;
            req_ready  <= (state_next == IDLE);
            resp_valid <= (state_next == DONE);
            resp_err   <= err_next;
            resp_rdata <= rdata_next;
            ram_we     <= (state_next == WR);
            ram_addr   <= ram_addr_next;
            ram_data   <= ram_data_next;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed requests push expected responses into a
// scoreboard queue; a monitor pops and checks them when resp_valid is seen.
module tb_load_store_unit;

    localparam int AW = 6;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [31:0]   req_addr = '0;
    logic [1:0]    req_size = 2'b00;
    logic          req_unsigned = 1'b0;
    logic [31:0]   req_wdata = '0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_data;
    logic          ram_we;
    logic [31:0]   ram_q;

    logic [31:0]   mem [0:(1<<AW)-1];
    exp_t          sbq [$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            edge_cnt = 0;
    int            we_cnt = 0;
    int            base;

    load_store_unit #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .ram_addr     (ram_addr),
        .ram_data     (ram_data),
        .ram_we       (ram_we),
        .ram_q        (ram_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Synchronous single-port RAM, read-before-write.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    always @(negedge clk) if (ram_we) we_cnt++;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && resp_valid) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got resp_valid rdata=0x%08h err=%0b, expected none",
                         resp_rdata, resp_err);
            end else begin
                e = sbq.pop_front();
                chk32("resp_rdata", resp_rdata, e.rdata);
                chk32("resp_err", {31'h0, resp_err}, {31'h0, e.err});
                chk32("resp_latency", edge_cnt - e.acc, e.lat);
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata, input logic expect_resp,
                         input logic [31:0] exp_rdata, input logic exp_err, input int lat);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (!req_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk32("req_ready_wait", {31'h0, req_ready}, 32'h1);
            return;
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        if (expect_resp) begin
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.lat   = lat;
            e.acc   = edge_cnt;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_we       = ~we;
        req_addr     = 32'hFFFF_FFFF;
        req_size     = 2'b11;
        req_unsigned = ~uns;
        req_wdata    = 32'h5A5A_5A5A;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((sbq.size() != 0 || !req_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk32("drain_outstanding", sbq.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk32("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk32("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk32("rst_resp_err", {31'h0, resp_err}, 32'h0);
        chk32("rst_resp_rdata", resp_rdata, 32'h0);
        chk32("rst_ram_we", {31'h0, ram_we}, 32'h0);
        chk32("rst_ram_addr", {26'h0, ram_addr}, 32'h0);
        chk32("rst_ram_data", ram_data, 32'h0);
        rst = 1'b0;

        // SW preload, then SB into lane 1 of word 1.
        issue(1'b1, 32'h04, 2'b10, 1'b0, 32'h1122_3344, 1'b1, 32'h0, 1'b0, 2);
        issue(1'b1, 32'h05, 2'b00, 1'b0, 32'hFFFF_FFAB, 1'b1, 32'h0, 1'b0, 4);
        drain();
        chk32("sb_merge_word1", mem[1], 32'h1122_AB44);
        issue(1'b0, 32'h04, 2'b10, 1'b0, 32'h0, 1'b1, 32'h1122_AB44, 1'b0, 3);

        // Half/byte loads with sign and zero extension.
        issue(1'b1, 32'h04, 2'b10, 1'b0, 32'h80FF_0000, 1'b1, 32'h0, 1'b0, 2);
        issue(1'b0, 32'h06, 2'b01, 1'b0, 32'h0, 1'b1, 32'hFFFF_80FF, 1'b0, 3);
        issue(1'b0, 32'h06, 2'b01, 1'b1, 32'h0, 1'b1, 32'h0000_80FF, 1'b0, 3);
        issue(1'b0, 32'h07, 2'b00, 1'b0, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0, 3);
        issue(1'b0, 32'h06, 2'b00, 1'b1, 32'h0, 1'b1, 32'h0000_00FF, 1'b0, 3);
        issue(1'b0, 32'h05, 2'b00, 1'b0, 32'h0, 1'b1, 32'h0000_0000, 1'b0, 3);
        issue(1'b0, 32'h104, 2'b10, 1'b0, 32'h0, 1'b1, 32'h80FF_0000, 1'b0, 3);
        drain();

        // Back-to-back SW then LW: exactly one write strobe.
        base = we_cnt;
        issue(1'b1, 32'h00, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0, 2);
        issue(1'b0, 32'h00, 2'b10, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 3);
        drain();
        chk32("sw_lw_we_pulses", we_cnt - base, 1);

        // SH into upper half of word 0.
        issue(1'b1, 32'h02, 2'b01, 1'b0, 32'hAAAA_1234, 1'b1, 32'h0, 1'b0, 4);
        drain();
        chk32("sh_merge_word0", mem[0], 32'h1234_BEEF);

        // Misaligned LW.
        base = we_cnt;
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b0, 32'h02, 2'b10, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1);
`else
        issue(1'b0, 32'h02, 2'b10, 1'b0, 32'h0, 1'b1, 32'h1234_BEEF, 1'b0, 3);
`endif
        drain();
        chk32("misalign_no_write", we_cnt - base, 0);

        // Reserved size store: error, no RAM access.
        base = we_cnt;
        issue(1'b1, 32'h00, 2'b11, 1'b0, 32'h0000_0055, 1'b1, 32'h0, 1'b1, 1);
        drain();
        chk32("rsvd_no_write", we_cnt - base, 0);
        chk32("rsvd_mem_word0", mem[0], 32'h1234_BEEF);

        // Reset during MERGE of an SB aborts with no write and no response.
        base = we_cnt;
        issue(1'b1, 32'h01, 2'b00, 1'b0, 32'h0000_0077, 1'b0, 32'h0, 1'b0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk32("abort_req_ready", {31'h0, req_ready}, 32'h1);
        chk32("abort_ram_we", {31'h0, ram_we}, 32'h0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk32("abort_no_write", we_cnt - base, 0);
        chk32("abort_mem_word0", mem[0], 32'h1234_BEEF);

        // Unit still works after the abort.
        issue(1'b0, 32'h00, 2'b00, 1'b1, 32'h0, 1'b1, 32'h0000_00EF, 1'b0, 3);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
